// File: rtl/fixed_point_muldiv.sv
// -----------------------------------------------------------------------------
// fixed_point_muldiv
//
// Sequential signed fixed-point multiply/divide unit for the raycaster
// datapath. Operands and result are two's-complement Q numbers with FRAC
// fractional bits. Multiply finishes in two cycles. Divide uses a restoring
// divider that produces one quotient bit per cycle for WIDTH+FRAC cycles.
// Every result saturates to the representable range.
//
// Ports:
//   clock        system clock, rising edge
//   resetn       asynchronous active-low reset
//   start        request, sampled only while idle
//   op           0 = a*b, 1 = a/b
//   a, b         signed Q operands, registered when the request is accepted
//   busy         high while an operation is in flight, including the done cycle
//   done         one-cycle pulse; result and flags are valid in that cycle
//   result       signed Q result, held until the next done
//   overflow     result was saturated
//   div_by_zero  divide with b = 0
// -----------------------------------------------------------------------------
module fixed_point_muldiv #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 10
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [WIDTH-1:0]   MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] MAX_MAG = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MIN_MAG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV, SIGN, DONE} state_t;

  state_t             state_q, state_d;
  logic               neg_q, neg_d;
  logic               a_neg_q, a_neg_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   amag_q, amag_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [N-1:0]       dvd_q, dvd_d;
  logic [N-1:0]       quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sat_mul;
  logic [WIDTH:0]     sat_div;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_sub;

  // Returns {overflow, value}. A negative magnitude of exactly 2^(WIDTH-1)
  // is MIN itself and passes through without overflow.
  function automatic logic [WIDTH:0] saturate(input logic [2*WIDTH-1:0] mag,
                                              input logic neg);
    logic [WIDTH-1:0] val;
    val = mag[WIDTH-1:0];
    if (!neg && (mag > MAX_MAG)) begin
      saturate = {1'b1, MAX_VAL};
    end else if (neg && (mag > MIN_MAG)) begin
      saturate = {1'b1, MIN_VAL};
    end else if (neg) begin
      saturate = {1'b0, -val};
    end else begin
      saturate = {1'b0, val};
    end
  endfunction

  // Magnitudes are WIDTH bits wide, so negating MIN yields 2^(WIDTH-1)
  // as an unsigned value rather than wrapping.
  assign a_mag_in = a[WIDTH-1] ? -a : a;
  assign b_mag_in = b[WIDTH-1] ? -b : b;

  assign prod    = {{WIDTH{1'b0}}, amag_q} * {{WIDTH{1'b0}}, bmag_q};
  assign sat_mul = saturate(prod >> FRAC, neg_q);
  assign sat_div = saturate({{(2*WIDTH-N){1'b0}}, quo_q}, neg_q);

  // Restoring step: the borrow out of the trial subtraction tells whether
  // the shifted remainder is at least the divisor.
  assign rem_shift = {rem_q, dvd_q[N-1]};
  assign rem_sub   = rem_shift - {1'b0, bmag_q};

  // Next-state and datapath logic for the whole FSM.
  always_comb begin
    state_d       = state_q;
    neg_d         = neg_q;
    a_neg_d       = a_neg_q;
    dbz_d         = dbz_q;
    amag_d        = amag_q;
    bmag_d        = bmag_q;
    dvd_d         = dvd_q;
    quo_d         = quo_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    overflow_d    = overflow_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          amag_d  = a_mag_in;
          bmag_d  = b_mag_in;
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
          a_neg_d = a[WIDTH-1];
          dbz_d   = 1'b0;
          if (!op) begin
            state_d = MUL;
          end else if (b == '0) begin
            dbz_d   = 1'b1;
            state_d = SIGN;
          end else begin
            dvd_d   = {a_mag_in, {FRAC{1'b0}}};
            quo_d   = '0;
            rem_d   = '0;
            cnt_d   = CW'(N);
            state_d = DIV;
          end
        end
      end
      MUL: begin
        result_d      = sat_mul[WIDTH-1:0];
        overflow_d    = sat_mul[WIDTH];
        div_by_zero_d = 1'b0;
        state_d       = DONE;
      end
      DIV: begin
        dvd_d = {dvd_q[N-2:0], 1'b0};
        if (!rem_sub[WIDTH]) begin
          rem_d = rem_sub[WIDTH-1:0];
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        if (dbz_q) begin
          result_d      = a_neg_q ? MIN_VAL : MAX_VAL;
          overflow_d    = 1'b0;
          div_by_zero_d = 1'b1;
        end else begin
          result_d      = sat_div[WIDTH-1:0];
          overflow_d    = sat_div[WIDTH];
          div_by_zero_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the upcoming state so they line
    // up exactly with the state they describe.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      neg_q         <= 1'b0;
      a_neg_q       <= 1'b0;
      dbz_q         <= 1'b0;
      amag_q        <= '0;
      bmag_q        <= '0;
      dvd_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      neg_q         <= neg_d;
      a_neg_q       <= a_neg_d;
      dbz_q         <= dbz_d;
      amag_q        <= amag_d;
      bmag_q        <= bmag_d;
      dvd_q         <= dvd_d;
      quo_q         <= quo_d;
      rem_q         <= rem_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      overflow_q    <= overflow_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign overflow    = overflow_q;
  assign div_by_zero = div_by_zero_q;

endmodule
